// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream bridge toward the IP core.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package axi_bridge_pkg;

  // Widest per-beat keep vector the helper functions accept (512-bit beats need 64).
  localparam int KEEP_MAX_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } bridge_state_e;

  // Number of client segments packed into one output beat.
  function automatic int calc_ratio(input int data_w, input int if_w);
    return (if_w > 0 && data_w >= if_w) ? data_w / if_w : 1;
  endfunction

  // Segment index width; never zero so the index register always exists.
  function automatic int calc_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // True when keep is non-zero and its set bits run contiguously from bit 0.
  function automatic logic keep_is_contig(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + 1'b1)) == '0);
  endfunction

  // Number of set bits in a keep vector.
  function automatic logic [7:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      cnt = cnt + {7'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi_bridge_beat_packer.sv
// Places client segments into their lanes of a beat and holds the finished beat.
// Latency: beat visible on m_axis_* one cycle after its closing segment is taken.
// Backpressure: beat held stable while tvalid & !tready; caller only closes a beat when the register is free.
module axi_bridge_beat_packer
  import axi_bridge_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16,
  parameter int IDX_W   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  seg_vld,
  input  logic                  seg_flush,
  input  logic                  seg_last,
  input  logic [IDX_W-1:0]      seg_idx,
  input  logic [IF_W-1:0]       seg_data,
  input  logic [IF_W/8-1:0]     seg_keep,
  input  logic [TUSER_W-1:0]    seg_user,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic [TUSER_W-1:0]    m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast
);

  localparam int SEG_KEEP_W = IF_W / 8;

  logic [DATA_W-1:0]   pack_data;
  logic [DATA_W/8-1:0] pack_keep;
  logic [DATA_W-1:0]   merged_data;
  logic [DATA_W/8-1:0] merged_keep;

  // Overlay the incoming segment on the partially filled beat.
  always_comb begin
    merged_data = pack_data;
    merged_keep = pack_keep;
    merged_data[int'(seg_idx)*IF_W +: IF_W]             = seg_data;
    merged_keep[int'(seg_idx)*SEG_KEEP_W +: SEG_KEEP_W] = seg_keep;
  end

  // Accumulate lanes; on the closing segment move the beat out and clear the lanes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_data     <= '0;
      pack_keep     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (seg_vld && !seg_flush) begin
        pack_data <= merged_data;
        pack_keep <= merged_keep;
      end
      if (seg_vld && seg_flush) begin
        pack_data     <= '0;
        pack_keep     <= '0;
        m_axis_tdata  <= merged_data;
        m_axis_tkeep  <= merged_keep;
        m_axis_tuser  <= seg_user;
        m_axis_tlast  <= seg_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_bridge_ip_tx.sv
// Packs Client-IF segments into wide AXI-Stream beats; drops packets lacking SOP. Optional stats: AXI_BRIDGE_IP_TX_STATS_EN.
// Latency: beat valid one cycle after the segment that completes it (lane RATIO-1 or EOP) is accepted.
// Backpressure: cl_rx_ready = bridge_enable & (!m_axis_tvalid | m_axis_tready); nothing is dropped while stalled.
module axi_bridge_ip_tx
  import axi_bridge_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IF_W-1:0]       cl_rx_data,
  input  logic [IF_W/8-1:0]     cl_rx_keep,
  input  logic                  cl_rx_valid,
  output logic                  cl_rx_ready,
  input  logic                  cl_rx_sop,
  input  logic                  cl_rx_eop,
  input  logic [TUSER_W-1:0]    cl_rx_user,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic [TUSER_W-1:0]    m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  bridge_enable,
  output logic [31:0]           stat_rx_frames,
  output logic [31:0]           stat_rx_bytes,
  output logic                  ev_err_sop_missing,
  output logic                  ev_err_keep_illegal
);

  localparam int RATIO      = calc_ratio(DATA_W, IF_W);
  localparam int IDX_W      = calc_idx_w(RATIO);
  localparam int SEG_KEEP_W = IF_W / 8;

  bridge_state_e        state;
  logic [IDX_W-1:0]     seg_idx;
  logic [TUSER_W-1:0]   user_q;
  logic                 accept;
  logic                 seg_fwd;
  logic                 seg_flush;
  logic                 keep_bad;
  logic [TUSER_W-1:0]   seg_user;

  assign cl_rx_ready = bridge_enable & (~m_axis_tvalid | m_axis_tready);
  assign accept      = cl_rx_valid & cl_rx_ready;
  // Only a SOP in IDLE or any segment in PKT carries packet data.
  assign seg_fwd     = accept & (((state == ST_IDLE) & cl_rx_sop) | (state == ST_PKT));
  assign seg_flush   = (seg_idx == IDX_W'(RATIO - 1)) | cl_rx_eop;
  // The SOP segment has not been captured yet, so its beat takes metadata straight from the input.
  assign seg_user    = (state == ST_IDLE) ? cl_rx_user : user_q;
  assign keep_bad    = cl_rx_eop ? ~keep_is_contig(KEEP_MAX_W'(cl_rx_keep))
                                 : (cl_rx_keep != {SEG_KEEP_W{1'b1}});

  // Packet framing FSM with lane index, SOP metadata capture and error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= ST_IDLE;
      seg_idx             <= '0;
      user_q              <= '0;
      ev_err_sop_missing  <= 1'b0;
      ev_err_keep_illegal <= 1'b0;
    end else begin
      ev_err_sop_missing  <= 1'b0;
      ev_err_keep_illegal <= 1'b0;
      if (accept) begin
        ev_err_keep_illegal <= keep_bad;
        case (state)
          ST_IDLE: begin
            if (cl_rx_sop) begin
              user_q  <= cl_rx_user;
              seg_idx <= seg_flush ? '0 : seg_idx + 1'b1;
              if (!cl_rx_eop) state <= ST_PKT;
            end else begin
              ev_err_sop_missing <= 1'b1;
              if (!cl_rx_eop) state <= ST_DROP;
            end
          end
          ST_PKT: begin
            seg_idx <= seg_flush ? '0 : seg_idx + 1'b1;
            if (cl_rx_eop) state <= ST_IDLE;
          end
          ST_DROP: begin
            if (cl_rx_eop) state <= ST_IDLE;
          end
          default: begin
            state   <= ST_IDLE;
            seg_idx <= '0;
          end
        endcase
      end
    end
  end

  axi_bridge_beat_packer #(
    .DATA_W  (DATA_W),
    .IF_W    (IF_W),
    .TUSER_W (TUSER_W),
    .IDX_W   (IDX_W)
  ) u_packer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .seg_vld       (seg_fwd),
    .seg_flush     (seg_flush),
    .seg_last      (cl_rx_eop),
    .seg_idx       (seg_idx),
    .seg_data      (cl_rx_data),
    .seg_keep      (cl_rx_keep),
    .seg_user      (seg_user),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

`ifdef AXI_BRIDGE_IP_TX_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] bytes_q;

  // Count delivered frames and bytes on every completed output handshake; both wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frames_q <= '0;
      bytes_q  <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      bytes_q <= bytes_q + 32'(keep_popcount(KEEP_MAX_W'(m_axis_tkeep)));
      if (m_axis_tlast) frames_q <= frames_q + 32'd1;
    end
  end

  assign stat_rx_frames = frames_q;
  assign stat_rx_bytes  = bytes_q;
`else
  assign stat_rx_frames = '0;
  assign stat_rx_bytes  = '0;
`endif

endmodule

// File: doc/axi_bridge_ip_tx.md
AXI_BRIDGE_IP_TX -- requirements
Module: axi_bridge_ip_tx
Interface
REQ-001 SHALL have parameter DATA_W, default 256, AXI-Stream data width toward IP.
REQ-002 SHALL have parameter IF_W, default 64, Client-IF segment width; RATIO=DATA_W/IF_W, integer ≥1.
REQ-003 SHALL have parameter TUSER_W, default 16, metadata width.
REQ-004 SHALL have port clk_i  in  1  sole clock; block uses one clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port cl_rx_data  in  IF_W  segment data from Protocol.
REQ-007 SHALL have port cl_rx_keep  in  IF_W/8  per-byte valid of segment.
REQ-008 SHALL have port cl_rx_valid  in  1  segment valid.
REQ-009 SHALL have port cl_rx_ready  out  1  segment accepted when valid&ready.
REQ-010 SHALL have port cl_rx_sop  in  1  first segment of packet.
REQ-011 SHALL have port cl_rx_eop  in  1  last segment of packet.
REQ-012 SHALL have port cl_rx_user  in  TUSER_W  metadata, sampled at SOP.
REQ-013 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DATA_W/DATA_W/8/TUSER_W/1/1  AXI-Stream beat to IP.
REQ-014 SHALL have port m_axis_tready  in  1  IP accepts beat.
REQ-015 SHALL have port bridge_enable  in  1  gates acceptance of new segments.
REQ-016 SHALL have port stat_rx_frames  out  32  count of beats accepted with tlast.
REQ-017 SHALL have port stat_rx_bytes  out  32  sum of set tkeep bits over accepted beats.
REQ-018 SHALL have port ev_err_sop_missing  out  1  one-cycle pulse: non-SOP segment accepted in IDLE.
REQ-019 SHALL have port ev_err_keep_illegal  out  1  one-cycle pulse: illegal keep on accepted segment.
Function
REQ-020 SHALL drive cl_rx_ready = bridge_enable & (!m_axis_tvalid | m_axis_tready), combinationally.
REQ-021 SHALL implement FSM IDLE/PKT/DROP: IDLE→PKT on accepted SOP without EOP; IDLE→DROP on accepted non-SOP without EOP; PKT/DROP→IDLE on accepted EOP; SOP+EOP in IDLE stays IDLE after emitting a beat.
REQ-022 SHALL place accepted segment k (0..RATIO-1) in lanes [k*IF_W +: IF_W] of pack register, keep likewise; unfilled lanes data 0, keep 0.
REQ-023 SHALL load output register when segment index RATIO-1 or EOP accepted; m_axis_tvalid rises next cycle (1-cycle latency); tlast = EOP; index returns to 0.
REQ-024 SHALL hold m_axis_* stable while tvalid&!tready.
REQ-025 SHALL drive m_axis_tuser with cl_rx_user captured at SOP for all beats of that packet.
REQ-026 SHALL discard segments in DROP (no beat emitted) and pulse ev_err_sop_missing on the entering segment; SOP seen in PKT is ignored as data continuation.
REQ-027 SHALL flag keep illegal when non-EOP keep is not all-ones, or EOP keep is zero or not LSB-contiguous; data still forwarded.
REQ-028 SHALL, on bridge_enable deassert mid-packet, stall without dropping; resume on reassert.
REQ-029 SHALL wrap stat counters modulo 2^32; stat_rx_bytes adds popcount(tkeep) on each tvalid&tready.
Reset
REQ-030 SHALL on rst_i clear FSM to IDLE, index to 0, m_axis_tvalid/tlast/tdata/tkeep/tuser to 0, stats 0, events 0, immediately and asynchronously.
REQ-031 SHALL discard any partial packet on reset; first post-reset segment must carry SOP.
Configuration
REQ-032 SHALL compile stat_rx_frames/stat_rx_bytes counters only when AXI_BRIDGE_IP_TX_STATS_EN is defined.
REQ-033 SHALL, without AXI_BRIDGE_IP_TX_STATS_EN, tie both stat outputs to 0 with no counter flops.
Structure
REQ-034 SHALL take FSM state enum, RATIO computation and keep-contiguity/popcount functions from shared package axi_bridge_pkg.
REQ-035 SHALL isolate lane placement and output register in sub-module axi_bridge_beat_packer.
Verification
REQ-036 SHALL test 4 full segments SOP..EOP, tready=1 -> one beat, tkeep=32'hFFFFFFFF, tlast=1 one cycle after 4th accept, frames=1, bytes=32.
REQ-037 SHALL test 6 segments, last keep 8'h0F -> beat1 tlast=0 full keep, beat2 tkeep=32'h00000FFF tlast=1, bytes=44.
REQ-038 SHALL test tready=0 for 10 cycles with tvalid=1 -> cl_rx_ready=0, m_axis_* unchanged, then drains on tready=1.
REQ-039 SHALL test 2 segments without SOP, second EOP, in IDLE -> no beat, ev_err_sop_missing pulses once; following proper packet delivered intact.
REQ-040 SHALL test mid-packet keep 8'hF0 -> ev_err_keep_illegal 1-cycle pulse, data forwarded; rst_i mid-packet -> tvalid 0 immediately, stats 0.
